// File: rtl/instr_fetch_unit_if.sv
// Instruction-memory fetch bus between the fetch stage and instruction memory.
//
// Handshake: imem_req is a request that the fetch side holds high, with
// imem_addr stable, until the memory answers. The memory answers by raising
// imem_ready in a cycle where imem_req is high, with imem_rdata valid in that
// same cycle for that cycle's imem_addr. imem_ready seen while imem_req is low
// has no meaning and is ignored. The fetch side may move imem_addr while
// imem_req is high only when it abandons the request because of a redirect
// or a reset.
interface instr_fetch_unit_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ready,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ready,
    output imem_rdata
  );
endinterface

// File: rtl/instr_fetch_unit.sv
// Fetch stage of the RISC-V core.
// Owns the fetch program counter, runs the instruction-memory request, and
// holds each fetched instruction (with its address) stable until decode
// consumes it. Downstream redirects restart fetching at a new address.
//
// Decode side: instr_valid marks an unconsumed instruction in instr/pc.
// Decode consumes it on any cycle with instr_valid && !stall. A redirect
// pulse overrides both stall and a same-cycle memory answer.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                 clk,
  input  logic                 rst_n,
  instr_fetch_unit_if.master   imem,
  input  logic                 stall,
  input  logic                 redirect,
  input  logic [31:0]          redirect_target,
  output logic                 instr_valid,
  output logic [31:0]          instr,
  output logic [31:0]          pc,
  output logic [31:0]          pc_plus4,
  output logic [24:0]          semi_instr,
  output logic [2:0]           opcode654,
  output logic                 misalign_err,
  output logic [1:0]           state_dbg
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_FETCH = 2'd1;
  localparam logic [1:0] ST_HOLD  = 2'd2;

  // Canonical NOP (addi x0, x0, 0) shown on the holding register after reset.
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  logic [1:0]  state_q,    state_d;
  logic [31:0] fetch_pc_q, fetch_pc_d;
  logic [31:0] instr_q,    instr_d;
  logic [31:0] pc_q,       pc_d;
  logic        valid_q,    valid_d;
  logic        misalign_q, misalign_d;

  logic        redirect_misaligned;
  logic [31:0] redirect_aligned;
  logic        fetch_done;

  assign redirect_misaligned = (redirect_target[1:0] != 2'b00);
  assign redirect_aligned    = {redirect_target[31:2], 2'b00};
  // A memory answer only counts while actually requesting.
  assign fetch_done          = (state_q == ST_FETCH) && imem.imem_ready;

  // Next-state logic: redirect first, then the per-state behaviour.
  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    instr_d    = instr_q;
    pc_d       = pc_q;
    valid_d    = valid_q;
    misalign_d = misalign_q;

    if (redirect) begin
      // Any in-flight answer is dropped; holding registers keep old contents.
      state_d    = ST_FETCH;
      fetch_pc_d = redirect_aligned;
      valid_d    = 1'b0;
      if (redirect_misaligned) begin
        misalign_d = 1'b1;
      end
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d = ST_FETCH;
        end
        ST_FETCH: begin
          if (fetch_done) begin
            instr_d    = imem.imem_rdata;
            pc_d       = fetch_pc_q;
            fetch_pc_d = fetch_pc_q + 32'd4;   // wraps mod 2^32, no flag
            valid_d    = 1'b1;
            state_d    = ST_HOLD;
          end
        end
        ST_HOLD: begin
          if (valid_q && !stall) begin
            valid_d = 1'b0;
            state_d = ST_FETCH;
          end
        end
        default: begin
          state_d = ST_IDLE;
          valid_d = 1'b0;
        end
      endcase
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      fetch_pc_q <= RESET_PC;
      instr_q    <= NOP_INSTR;
      pc_q       <= RESET_PC;
      valid_q    <= 1'b0;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      instr_q    <= instr_d;
      pc_q       <= pc_d;
      valid_q    <= valid_d;
      misalign_q <= misalign_d;
    end
  end

  // Memory request is a pure function of state; address follows fetch_pc.
  always_comb begin
    imem.imem_req  = (state_q == ST_FETCH);
    imem.imem_addr = fetch_pc_q;
  end

  // Decode-facing outputs and sign-extender fields from the holding registers.
  always_comb begin
    instr_valid  = valid_q;
    instr        = instr_q;
    pc           = pc_q;
    pc_plus4     = pc_q + 32'd4;
    semi_instr   = instr_q[31:7];
    opcode654    = instr_q[6:4];
    misalign_err = misalign_q;
    state_dbg    = state_q;
  end

endmodule

// File: doc/instr_fetch_unit.md
# instr_fetch_unit

- Fetch stage of the RISC-V core.
- Owns the program counter and runs the instruction-memory handshake.
- Holds each fetched instruction stable until decode consumes it.
- Drives the instruction fields that feed the immediate sign extender (instr[31:7] and instr[6:4]).
- Accepts branch/jump redirects computed downstream from the extended immediate.

## Interface

Parameters:
- RESET_PC, 32'h0000_0000, first fetch address after reset; must be word-aligned.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst_n  in  1  reset; synchronous, active-low.
- imem_req  out  1  fetch request; high only in FETCH.
- imem_addr  out  32  fetch address, word-aligned; equals fetch_pc.
- imem_ready  in  1  memory returns imem_rdata for this cycle's imem_addr.
- imem_rdata  in  32  instruction word; sampled only when imem_req && imem_ready.
- stall  in  1  decode/execute cannot accept the held instruction this cycle.
- redirect  in  1  taken branch/jump; single-cycle pulse.
- redirect_target  in  32  new fetch address.
- instr_valid  out  1  instr/pc hold an unconsumed instruction.
- instr  out  32  held instruction.
- pc  out  32  address of held instruction.
- pc_plus4  out  32  pc + 4, modulo 2^32.
- semi_instr  out  25  instr[31:7], to the sign extender.
- opcode654  out  3  instr[6:4], to the sign extender.
- misalign_err  out  1  sticky; set by a redirect with target[1:0] != 0.

## Operation

- Internal registers:
  - fetch_pc: 32 bits.
  - FSM state: IDLE, FETCH, HOLD.
  - Holding registers for instr and pc.
- IDLE:
  - imem_req = 0.
  - Always goes to FETCH next cycle.
- FETCH:
  - imem_req = 1, imem_addr = fetch_pc.
  - On imem_ready without redirect:
    - instr <= imem_rdata, pc <= fetch_pc.
    - fetch_pc <= fetch_pc + 4.
    - instr_valid <= 1, go to HOLD.
  - Without imem_ready: stay in FETCH; addr is held.
- HOLD:
  - imem_req = 0; instr and pc are held.
  - Consumption happens on a cycle with instr_valid && !stall.
  - On consumption: instr_valid <= 0, go to FETCH.
  - While stall = 1: remain in HOLD, all outputs unchanged.
- Redirect (any state; priority over stall and imem_ready):
  - fetch_pc <= {redirect_target[31:2], 2'b00}.
  - instr_valid <= 0, go to FETCH.
  - In FETCH with imem_ready in the same cycle: returned data is discarded; instr and pc are not updated.
  - redirect_target[1:0] != 0: misalign_err <= 1, and the address is still aligned as above.
- Arithmetic:
  - fetch_pc + 4 and pc + 4 wrap mod 2^32 (0xFFFF_FFFC -> 0x0000_0000).
  - No error is flagged on wrap.
- semi_instr, opcode654 and pc_plus4 are combinational from the holding registers.

## Timing

- Reset values (rst_n low at a rising edge):
  - state = IDLE, fetch_pc = RESET_PC.
  - imem_req = 0, imem_addr = RESET_PC.
  - instr = 32'h0000_0013 (NOP), pc = RESET_PC, pc_plus4 = RESET_PC + 4.
  - instr_valid = 0, misalign_err = 0.
  - semi_instr = 25'h0, opcode654 = 3'b001.
- Reset mid-transaction:
  - Any in-flight fetch is abandoned.
  - imem_req drops on the edge where rst_n is sampled low.
- First request: imem_req rises one cycle after the first edge with rst_n high.
- imem_ready to instr_valid: 1 cycle.
- Throughput:
  - Minimum 2 cycles per instruction (FETCH with ready, then HOLD without stall).
  - Each memory wait cycle and each stall cycle adds 1.
- Redirect effect:
  - Seen on imem_addr in the next cycle, with imem_req = 1.
  - instr_valid is low in that cycle.
- imem_addr is stable for the whole time imem_req is high, unless a redirect occurs.

## Test plan

- Reset, RESET_PC=0x100, rst_n low 2 cycles, then high:
  - During reset: imem_req=0, instr_valid=0, instr=0x00000013, pc_plus4=0x104.
  - One cycle after release: imem_req=1, imem_addr=0x100.
- Zero-wait fetch, imem_rdata=0x00500093 at 0x100:
  - Next cycle: instr_valid=1, pc=0x100, semi_instr=0x000A001, opcode654=3'b001.
  - After consumption: imem_addr=0x104.
- Wait states, imem_ready low 3 cycles at 0x104:
  - imem_req=1 and imem_addr=0x104 for 4 cycles.
  - instr_valid=0 throughout; capture on the 4th cycle.
- Stall high 5 cycles in HOLD:
  - instr and pc unchanged, imem_req=0, instr_valid=1.
  - One cycle after stall falls: instr_valid=0, imem_req=1.
- Redirect pulses in HOLD:
  - Target 0x200: next cycle instr_valid=0, imem_addr=0x200, misalign_err=0.
  - Later target 0x203: imem_addr=0x200, misalign_err=1, and it stays 1 until reset.
- Redirect to 0x300 in the same cycle as imem_ready in FETCH:
  - Data is dropped: instr and pc unchanged, instr_valid=0.
  - Next cycle: imem_addr=0x300.
  - Also cover redirect and stall together in HOLD: redirect wins.
